// File: rtl/chs_pkg.sv
// Shared types and defaults for the chs_conf serial receiver.
package chs_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2
    } chs_state_e;

    localparam int unsigned CHS_CONF_W  = 8;
    localparam int unsigned CHS_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/chs_conf_receiver_ones_counter.sv
// Ones counter for the receiver: counts accepted 1 bits and reports even/odd.
module chs_ones_counter
    import chs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             is_even_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign is_even_o = ~count_q[0];

endmodule

// File: rtl/chs_conf_receiver.sv
// Serial-to-parallel receiver for the chs_conf byte: MSB-first data, even parity, inter-bit timeout.
module chs_conf_receiver
    import chs_pkg::*;
#(
    parameter int unsigned WIDTH   = CHS_CONF_W,
    parameter int unsigned TIMEOUT = CHS_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             inBit,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] chs_conf,
    output logic             conf_valid,
    output logic             parity_err,
    output logic             timeout_err,
    output logic             busy,
    output logic [CNT_W-1:0] ones_count
);

    localparam int unsigned IDX_W = $clog2(WIDTH + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    chs_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [WIDTH-1:0] conf_q, conf_d;
    logic             conf_valid_q, conf_valid_d;
    logic             perr_q, perr_d;
    logic             terr_q, terr_d;
    logic             busy_q, busy_d;
    logic             cnt_clr_c;
    logic             cnt_en_c;
    logic             cnt_even;

    chs_ones_counter u_ones (
        .clk       (clk),
        .rst_n     (reset),
        .clr_i     (cnt_clr_c),
        .en_i      (cnt_en_c),
        .count_o   (ones_count),
        .is_even_o (cnt_even)
    );

    // Next-state: start has priority, then bit strobes, then the idle timer.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        conf_d       = conf_q;
        conf_valid_d = 1'b0;
        perr_d       = 1'b0;
        terr_d       = 1'b0;
        cnt_clr_c    = 1'b0;
        cnt_en_c     = 1'b0;

        if (start) begin
            state_d   = S_DATA;
            shreg_d   = '0;
            idx_d     = '0;
            timer_d   = '0;
            cnt_clr_c = 1'b1;
        end else begin
            case (state_q)
                S_DATA, S_PARITY: begin
                    if (bit_valid) begin
                        timer_d  = '0;
                        cnt_en_c = inBit;
                        if (state_q == S_DATA) begin
                            shreg_d = {shreg_q[WIDTH-2:0], inBit};
                            idx_d   = idx_q + IDX_W'(1);
                            if (idx_q == IDX_W'(WIDTH - 1)) begin
                                state_d = S_PARITY;
                            end
                        end else begin
                            // Total ones is even when the running parity and the parity bit agree.
                            state_d = S_IDLE;
                            if (cnt_even ^ inBit) begin
                                conf_d       = shreg_q;
                                conf_valid_d = 1'b1;
                            end else begin
                                perr_d = 1'b1;
                            end
                        end
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        timer_d = '0;
                        terr_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            conf_q       <= '0;
            conf_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            terr_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            conf_q       <= conf_d;
            conf_valid_q <= conf_valid_d;
            perr_q       <= perr_d;
            terr_q       <= terr_d;
            busy_q       <= busy_d;
        end
    end

    assign chs_conf    = conf_q;
    assign conf_valid  = conf_valid_q;
    assign parity_err  = perr_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_chs_conf_receiver.sv
// Self-checking bench for chs_conf_receiver: directed frames plus randomized frames vs a frame-level model.
module tb_chs_conf_receiver;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic         inBit;
    logic         bit_valid;
    logic [W-1:0] chs_conf;
    logic         conf_valid;
    logic         parity_err;
    logic         timeout_err;
    logic         busy;
    logic [3:0]   ones_count;

    int unsigned  n_checks;
    int unsigned  n_fail;
    logic [W-1:0] exp_conf;

    chs_conf_receiver #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .inBit       (inBit),
        .bit_valid   (bit_valid),
        .chs_conf    (chs_conf),
        .conf_valid  (conf_valid),
        .parity_err  (parity_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .ones_count  (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_start_busy"}, 32'(busy), 32'd1);
        chk({tag, "_start_ones"}, 32'(ones_count), 32'd0);
        chk({tag, "_start_pulses"}, {29'd0, conf_valid, parity_err, timeout_err}, 32'd0);
    endtask

    task automatic send_bit(input logic b, input int gap);
        idle(gap);
        bit_valid = 1'b1;
        inBit     = b;
        tick();
        bit_valid = 1'b0;
        inBit     = 1'b0;
    endtask

    // Full frame; gap < 0 picks a random 0..3 idle cycles before each bit.
    task automatic send_frame(input string tag, input logic [W-1:0] data, input logic par,
                              input int gap);
        int unsigned ones;
        int unsigned total;
        logic        good;
        ones = 0;
        do_start(tag);
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(data[i], (gap < 0) ? int'($urandom_range(0, 3)) : gap);
            ones += 32'(data[i]);
        end
        chk({tag, "_data_ones"}, 32'(ones_count), ones);
        chk({tag, "_data_busy"}, 32'(busy), 32'd1);
        send_bit(par, (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        total = ones + 32'(par);
        good  = (total % 2) == 0;
        if (good) exp_conf = data;
        chk({tag, "_conf_valid"}, 32'(conf_valid), 32'(good));
        chk({tag, "_parity_err"}, 32'(parity_err), 32'(!good));
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_chs_conf"}, 32'(chs_conf), 32'(exp_conf));
        chk({tag, "_ones_total"}, 32'(ones_count), total);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_pulses_drop"}, {29'd0, conf_valid, parity_err, timeout_err}, 32'd0);
        chk({tag, "_ones_hold"}, 32'(ones_count), total);
    endtask

    // Start, k bits, then silence until the inter-bit timeout aborts the frame.
    task automatic timeout_frame(input string tag, input int k);
        int unsigned ones;
        logic [W-1:0] d;
        ones = 0;
        d    = W'($urandom);
        do_start(tag);
        for (int i = 0; i < k; i++) begin
            send_bit(d[i], 0);
            ones += 32'(d[i]);
        end
        idle(TO - 1);
        chk({tag, "_pre_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_pre_timeout_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd1);
        chk({tag, "_timeout_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout_other"}, {30'd0, conf_valid, parity_err}, 32'd0);
        chk({tag, "_timeout_conf"}, 32'(chs_conf), 32'(exp_conf));
        chk({tag, "_timeout_ones"}, 32'(ones_count), ones);
        tick();
        chk({tag, "_timeout_drop"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic         p;
        n_checks  = 0;
        n_fail    = 0;
        exp_conf  = '0;
        reset     = 1'b0;
        start     = 1'b0;
        inBit     = 1'b0;
        bit_valid = 1'b0;
        idle(3);
        chk("rst_conf", 32'(chs_conf), 32'd0);
        chk("rst_flags", {28'd0, conf_valid, parity_err, timeout_err, busy}, 32'd0);
        chk("rst_ones", 32'(ones_count), 32'd0);
        reset = 1'b1;
        tick();

        // Strobes while idle, and with start, must not be counted.
        bit_valid = 1'b1;
        inBit     = 1'b1;
        tick();
        chk("idle_bv_busy", 32'(busy), 32'd0);
        chk("idle_bv_ones", 32'(ones_count), 32'd0);
        start = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        chk("start_bv_ones", 32'(ones_count), 32'd0);

        send_frame("a5", 8'hA5, 1'b0, 0);
        send_frame("07_bad", 8'h07, 1'b0, 1);
        send_frame("ff_spaced", 8'hFF, 1'b0, 2);
        send_frame("00", 8'h00, 1'b0, 0);
        timeout_frame("to4", 4);

        // Restart mid-frame, no error pulse.
        do_start("rs");
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        send_frame("3c_restart", 8'h3C, 1'b0, 0);

        // Async reset mid-frame.
        do_start("ar");
        for (int i = 0; i < 6; i++) send_bit(1'b1, 0);
        #2 reset = 1'b0;
        #1;
        chk("ar_conf", 32'(chs_conf), 32'd0);
        chk("ar_flags", {28'd0, conf_valid, parity_err, timeout_err, busy}, 32'd0);
        chk("ar_ones", 32'(ones_count), 32'd0);
        exp_conf = '0;
        tick();
        reset = 1'b1;
        tick();
        send_frame("81", 8'h81, 1'b0, 0);

        // Randomized frames with random parity and spacing.
        for (int n = 0; n < 20; n++) begin
            d = W'($urandom);
            p = 1'($urandom);
            send_frame("rnd", d, p, -1);
            idle(int'($urandom_range(0, 2)));
        end
        for (int n = 0; n < 3; n++) begin
            timeout_frame("rnd_to", int'($urandom_range(0, W)));
        end
        send_frame("final", 8'h5A, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
